// File: rtl/fe_pkg.sv
// Shared types and defaults for the front-end fetch buffer.
// fe_entry_t is the default-width buffer entry. fe_fifo_ring takes the entry
// type as a type parameter, so the top can use non-default widths.
package fe_pkg;

    localparam int FE_FBUF_DEPTH_DEFAULT = 4;
    localparam int FE_PC_W_DEFAULT       = 64;
    localparam int FE_INST_W_DEFAULT     = 32;

    typedef struct packed {
        logic [FE_PC_W_DEFAULT-1:0]   pc;
        logic [FE_INST_W_DEFAULT-1:0] inst;
        logic                         fault;
    } fe_entry_t;

endpackage

// File: rtl/fe_fifo_ring.sv
// Ring-buffer storage for fetch entries.
// The write and read pointers wrap naturally. count tells full from empty.
// clear takes priority over push and pop.
// head is zero whenever the ring is empty, so an empty or reset buffer
// presents all-zero decode fields.
module fe_fifo_ring
    import fe_pkg::*;
#(
    parameter int  DEPTH   = FE_FBUF_DEPTH_DEFAULT,
    parameter type entry_t = fe_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    input  logic                         clear,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Entry storage: write at the tail. The caller never pushes while clearing or full.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // The head comes from registered storage. It is zero while the ring is empty.
    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fe_fetch_buffer.sv
// Fetch buffer between the I$ response port and decode.
// Issue credit: alloc_ok counts buffered entries plus live (not-to-be-dropped)
// outstanding requests, so every live response is guaranteed a slot.
// Flush: everything still in flight is marked for discard.
// Optional build macro FE_FBUF_PERF_EN enables the saturating drop_total counter.
// Handshakes: a transfer happens on a cycle where valid && ready is high at
// the rising clock edge. Neither ready depends combinationally on the
// partner's valid. rsp_ready and alloc_ok come from registered state only.
module fe_fetch_buffer
    import fe_pkg::*;
#(
    parameter int DEPTH  = FE_FBUF_DEPTH_DEFAULT,
    parameter int PC_W   = FE_PC_W_DEFAULT,
    parameter int INST_W = FE_INST_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_issue,
    output logic                         alloc_ok,
    input  logic                         rsp_valid,
    input  logic [PC_W-1:0]              rsp_pc,
    input  logic [INST_W-1:0]            rsp_inst,
    input  logic                         rsp_fault,
    output logic                         rsp_ready,
    input  logic                         flush,
    output logic                         dec_valid,
    output logic [PC_W-1:0]              dec_pc,
    output logic [INST_W-1:0]            dec_inst,
    output logic                         dec_fault,
    input  logic                         dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [31:0]                  drop_total
);

    localparam int CW = $clog2(DEPTH+1);
    // One extra bit of headroom for the outstanding/drop counters.
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              fault;
    } fbuf_entry_t;

    logic [OW-1:0] out_q;
    logic [OW-1:0] drop_q;
    logic [OW-1:0] out_next;
    logic [OW-1:0] live_pending;
    logic [OW:0]   load;
    logic          rsp_fire;
    logic          discard;
    logic          push;
    logic          pop;
    fbuf_entry_t   push_data;
    fbuf_entry_t   head;

    // Accept control: while drops are pending, responses are always taken and thrown away.
    always_comb begin
        rsp_ready    = (drop_q != '0) || (count < CW'(DEPTH));
        rsp_fire     = rsp_valid && rsp_ready;
        discard      = rsp_fire && (flush || (drop_q != '0));
        push         = rsp_fire && !discard;
        pop          = dec_valid && dec_ready && !flush;
        out_next     = out_q + OW'(req_issue) - OW'(rsp_fire);
        live_pending = out_q - drop_q;
        load         = (OW+1)'(count) + (OW+1)'(live_pending);
        alloc_ok     = load < (OW+1)'(DEPTH);
        push_data    = '{pc: rsp_pc, inst: rsp_inst, fault: rsp_fault};
    end

    // Outstanding and drop counters. A flush turns everything in flight,
    // including a request issued in the same cycle, into pending drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            out_q <= out_next;
            if (flush) begin
                drop_q <= out_next;
            end else if (rsp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - OW'(1);
            end
        end
    end

    fe_fifo_ring #(
        .DEPTH   (DEPTH),
        .entry_t (fbuf_entry_t)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (flush),
        .head      (head),
        .count     (count)
    );

    // Decode side sees only registered head storage.
    always_comb begin
        dec_valid = (count != '0);
        dec_pc    = head.pc;
        dec_inst  = head.inst;
        dec_fault = head.fault;
    end

`ifdef FE_FBUF_PERF_EN
    logic [31:0] drop_cnt;

    // Saturating count of discarded responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (discard && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign drop_total = drop_cnt;
`else
    assign drop_total = '0;
`endif

    // Protocol and invariant checks.
    a_issue_credit: assert property (@(posedge clk) disable iff (!rst_n) !(req_issue && !alloc_ok));
    a_out_bound:    assert property (@(posedge clk) disable iff (!rst_n) out_q <= OW'(DEPTH));
    a_drop_bound:   assert property (@(posedge clk) disable iff (!rst_n) drop_q <= out_q);
    a_no_orphan:    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_valid && (out_q == '0)));

endmodule

// File: tb/tb_fe_fetch_buffer.sv
// Testbench for fe_fetch_buffer: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_fe_fetch_buffer;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int EW     = PC_W + INST_W + 1;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              req_issue;
    logic              alloc_ok;
    logic              rsp_valid;
    logic [PC_W-1:0]   rsp_pc;
    logic [INST_W-1:0] rsp_inst;
    logic              rsp_fault;
    logic              rsp_ready;
    logic              flush;
    logic              dec_valid;
    logic [PC_W-1:0]   dec_pc;
    logic [INST_W-1:0] dec_inst;
    logic              dec_fault;
    logic              dec_ready;
    logic [CW-1:0]     count;
    logic [31:0]       drop_total;

    fe_fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_issue  (req_issue),
        .alloc_ok   (alloc_ok),
        .rsp_valid  (rsp_valid),
        .rsp_pc     (rsp_pc),
        .rsp_inst   (rsp_inst),
        .rsp_fault  (rsp_fault),
        .rsp_ready  (rsp_ready),
        .flush      (flush),
        .dec_valid  (dec_valid),
        .dec_pc     (dec_pc),
        .dec_inst   (dec_inst),
        .dec_fault  (dec_fault),
        .dec_ready  (dec_ready),
        .count      (count),
        .drop_total (drop_total)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / reference model state
    logic [EW-1:0] exp_q[$];   // {pc, inst, fault} in decode order
    int            m_out;      // requests issued, not yet answered
    int            m_drop;     // answers still to be thrown away
    int            m_drops;    // discarded responses since reset
    int            n_cmp;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_drop_total();
`ifdef FE_FBUF_PERF_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    function automatic logic model_alloc();
        return (exp_q.size() + m_out - m_drop) < DEPTH;
    endfunction

    function automatic logic model_ready();
        return (m_drop > 0) || (exp_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_out   = 0;
        m_drop  = 0;
        m_drops = 0;
    endtask

    task automatic check_outputs();
        logic [EW-1:0] h;
        check("count", 64'(count), 64'(exp_q.size()));
        check("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
        check("alloc_ok", 64'(alloc_ok), 64'(model_alloc()));
        check("rsp_ready", 64'(rsp_ready), 64'(model_ready()));
        check("drop_total", 64'(drop_total), 64'(exp_drop_total()));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("dec_pc", dec_pc, h[EW-1 -: PC_W]);
            check("dec_inst", 64'(dec_inst), 64'(h[INST_W:1]));
            check("dec_fault", 64'(dec_fault), 64'(h[0]));
        end
    endtask

    task automatic check_reset_values();
        check("rst_count", 64'(count), 64'd0);
        check("rst_dec_valid", 64'(dec_valid), 64'd0);
        check("rst_dec_pc", dec_pc, 64'd0);
        check("rst_dec_inst", 64'(dec_inst), 64'd0);
        check("rst_dec_fault", 64'(dec_fault), 64'd0);
        check("rst_alloc_ok", 64'(alloc_ok), 64'd1);
        check("rst_rsp_ready", 64'(rsp_ready), 64'd1);
        check("rst_drop_total", 64'(drop_total), 64'd0);
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic iss, input logic rv, input logic [EW-1:0] ent,
                              input logic fl, input logic dr);
        logic fire;
        logic deq;
        fire = rv && model_ready();
        deq  = (exp_q.size() != 0) && dr;
        if (fl) begin
            if (fire) m_drops++;
            m_out  = m_out + int'(iss) - int'(fire);
            m_drop = m_out;
            exp_q.delete();
        end else begin
            if (deq) void'(exp_q.pop_front());
            if (fire) begin
                if (m_drop > 0) begin
                    m_drop--;
                    m_drops++;
                end else begin
                    exp_q.push_back(ent);
                end
            end
            m_out = m_out + int'(iss) - int'(fire);
        end
    endtask

    // Driver: one clock per call; inputs applied and outputs checked at the falling edge.
    task automatic cycle(input logic iss, input logic rv, input logic [PC_W-1:0] pc,
                         input logic [INST_W-1:0] inst, input logic flt,
                         input logic fl, input logic dr);
        @(negedge clk);
        req_issue = iss;
        rsp_valid = rv;
        rsp_pc    = pc;
        rsp_inst  = inst;
        rsp_fault = flt;
        flush     = fl;
        dec_ready = dr;
        check_outputs();
        model_step(iss, rv, {pc, inst, flt}, fl, dr);
    endtask

    task automatic idle(input logic dr);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, dr);
    endtask

    task automatic issue_one();
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic respond(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst);
        cycle(1'b0, 1'b1, pc, inst, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic iss, rv, fl, dr;
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        rst_n     = 1'b0;
        req_issue = 1'b0;
        rsp_valid = 1'b0;
        rsp_pc    = '0;
        rsp_inst  = '0;
        rsp_fault = 1'b0;
        flush     = 1'b0;
        dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic fill: four issues, four responses held back, then in-order drain.
        repeat (4) issue_one();
        for (int i = 0; i < 4; i++) begin
            respond(64'h1000 + 64'(4 * i), 32'hA000_0000 + 32'(i));
        end
        // Full: dec_ready=1 does not open rsp_ready this cycle; the next cycle does.
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Latency: entry visible exactly one cycle after the response fires.
        issue_one();
        respond(64'h2000, 32'h1234_5678);
        check("lat_no_bypass", 64'(dec_valid), 64'd0);
        idle(1'b1);
        idle(1'b0);

        // Flush with two in flight plus a same-cycle issue: three drops.
        issue_one();
        issue_one();
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) respond(64'hDEAD_0000 + 64'(i), 32'hBAD0_0000);
        issue_one();
        respond(64'h4000, 32'h4444_4444);
        idle(1'b1);
        check("flush_drop_total", 64'(drop_total), 64'(exp_drop_total()));
        idle(1'b0);

        // Flush with a response firing in the same cycle while count=2.
        repeat (3) issue_one();
        respond(64'h3000, 32'h3000_0000);
        respond(64'h3004, 32'h3000_0004);
        cycle(1'b0, 1'b1, 64'h3008, 32'h3000_0008, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // Reset mid-stream with count=3 and one request outstanding.
        repeat (4) issue_one();
        for (int i = 0; i < 3; i++) respond(64'h5000 + 64'(4 * i), 32'h5555_0000 + 32'(i));
        @(negedge clk);
        req_issue = 1'b0;
        rsp_valid = 1'b0;
        flush     = 1'b0;
        dec_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);

        // Random traffic under the issue/response protocol.
        for (int i = 0; i < 600; i++) begin
            iss = model_alloc() && (m_out < DEPTH) && ($urandom_range(0, 1) == 1);
            rv  = (m_out > 0) && ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            dr  = ($urandom_range(0, 1) == 1);
            cycle(iss, rv, {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)), fl, dr);
        end
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fe_fetch_buffer.md
Name: fe_fetch_buffer

Overview:
Decoupling queue between the front-end I$ hook port and decode. It captures {pc, inst, fault} responses from the I$ port into a DEPTH-entry FIFO and presents them in order to decode. It gives the PC generator an issue credit, so requests are never issued without guaranteed buffer space. On a redirect flush it drops all stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
PC_W, 64, fetch PC width
INST_W, 32, instruction word width

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
req_issue  in  1  pulse: PC generator's I$ request fired this cycle
alloc_ok  out  1  a new request may be issued this cycle
rsp_valid  in  1  I$ port response valid
rsp_pc  in  PC_W  response PC
rsp_inst  in  INST_W  response instruction
rsp_fault  in  1  response fetch fault
rsp_ready  out  1  buffer accepts or discards response
flush  in  1  redirect; kill queue and all outstanding responses
dec_valid  out  1  head entry valid
dec_pc  out  PC_W  head PC
dec_inst  out  INST_W  head instruction
dec_fault  out  1  head fault
dec_ready  in  1  decode consumes head
count  out  $clog2(DEPTH+1)  occupied entries
drop_total  out  32  discarded-response counter (feature-gated)

Behaviour:
- Reset (async assert, sync-released by the clock domain):
  - count=0, out_q=0, drop_q=0, pointers=0.
  - dec_valid=0, dec_pc/dec_inst/dec_fault=0, alloc_ok=1, rsp_ready=1, drop_total=0.
- State:
  - out_q counts requests issued but not yet answered.
  - drop_q <= out_q counts outstanding responses that must be discarded.
- Response acceptance:
  - rsp_fire = rsp_valid && rsp_ready.
  - rsp_ready = (drop_q!=0) || (count<DEPTH).
  - If drop_q!=0, a fired response is discarded (no enqueue) and drop_q decrements. Otherwise it is enqueued at the tail.
- Latency: an enqueued entry appears at dec_* the next cycle. There is no combinational bypass from rsp_* to dec_*.
- dec_* is driven from registered head storage. dec_valid = count!=0.
- Dequeue: deq_fire = dec_valid && dec_ready.
- Full FIFO with simultaneous dequeue: rsp_ready stays 0 because it does not look at dec_ready. The next cycle accepts.
- Empty FIFO with simultaneous enqueue: the entry becomes visible the next cycle. count goes 0 to 1.
- Counter update: out_q_next = out_q + req_issue - rsp_fire, covering both plain responses and discarded ones.
- alloc_ok = (count + (out_q - drop_q)) < DEPTH, computed from registered state only.
- Issue discipline: upstream issues only when alloc_ok. A req_issue while alloc_ok=0 is a protocol error, caught by a simulation assertion.
- Flush (priority over everything):
  - Next cycle: count=0, pointers reset, dec_valid=0.
  - drop_q <= out_q + req_issue - rsp_fire. A req_issue in the flush cycle counts as stale.
  - A response firing in the flush cycle is discarded.
  - A dec fire in the flush cycle needs no extra action.
  - out_q follows the normal rule.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- No over- or underflow is possible under the protocol. Assertions check:
  - out_q <= DEPTH
  - drop_q <= out_q
  - no rsp_valid while out_q==0

Optional Feature:
FE_FBUF_PERF_EN
- Defined: drop_total increments by 1 per discarded response, saturating at 32'hFFFF_FFFF. It resets to 0.
- Undefined: drop_total is tied to 0 and there is no counter logic. The port list is identical in both builds.

Decomposition:
- fe_pkg holds:
  - typedef fe_entry_t: packed {pc[PC_W], inst[INST_W], fault}
  - FE_FBUF_DEPTH_DEFAULT=4
- One sub-module: fe_fifo_ring. It holds parameterised storage of fe_entry_t, wr/rd pointers and count, with push/pop/clear ports.
- fe_fetch_buffer owns the credit and drop logic.

Test Plan:
- Basic fill:
  - 4 issues, then responses pc=0x1000,0x1004,0x1008,0x100C with dec_ready=0.
  - Expect count=4, alloc_ok=0 after the fourth issue, rsp_ready=0 with no further responses pending.
  - Then dec_ready=1 drains in order with 1 entry per cycle.
- Latency: empty buffer, one response pc=0x2000, inst=0x1234_5678 -> dec_valid rises exactly 1 cycle after rsp_fire with matching pc/inst.
- Flush with in-flight:
  - 2 issued, 0 answered, flush with req_issue=1 -> drop_q=3.
  - Next 3 responses are accepted with rsp_ready=1 and discarded.
  - Fourth response pc=0x4000 appears at dec_pc.
  - drop_total=3 with FE_FBUF_PERF_EN defined.
- Simultaneous flush and response: response fires in the flush cycle with count=2 -> next cycle count=0, dec_valid=0, response not visible.
- Full with dequeue: count=4, rsp_valid=1, dec_ready=1 -> this cycle rsp_ready=0. Next cycle the response is accepted, count=4 afterward.
- Reset mid-stream: rst_n asserted with count=3, out_q=1 -> all outputs are at reset values immediately (async), and alloc_ok=1 after release.
